// File: rtl/conv1_mac_acc.sv
// conv1 accumulation stage: sums KERNEL_LEN signed products plus a per-window bias,
// then rescales with rounding, saturates to 14-bit signed and optionally applies ReLU.
module conv1_mac_acc #(
    parameter int KERNEL_LEN = 25,
    parameter int SHIFT      = 8,
    parameter int RELU_EN    = 1,
    parameter int ACC_W      = 29
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic signed [22:0] in_prod,
    input  logic signed [22:0] in_bias,
    input  logic               in_valid,
    output logic               in_ready,
    output logic        [13:0] out_data,
    output logic               out_valid,
    input  logic               out_ready
);
    localparam int CNT_W = $clog2(KERNEL_LEN);
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(8191);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-8192);

    typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [13:0]             out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    logic                    accept, last;
    logic signed [ACC_W-1:0] prod_x, bias_x, sum, rnd, r;
    logic [13:0]             fin;

    assign prod_x = {{(ACC_W-23){in_prod[22]}}, in_prod};
    assign bias_x = {{(ACC_W-23){in_bias[22]}}, in_bias};
    assign accept = in_valid && in_ready;
    assign last   = (count_q == CNT_W'(KERNEL_LEN - 1));

    // The first product of a window starts from the bias instead of the stale accumulator.
    always_comb begin
        sum = ((count_q == '0) ? bias_x : acc_q) + prod_x;
        rnd = sum + RND;
        r   = rnd >>> SHIFT;
        if (r > SAT_MAX)      fin = 14'h1FFF;
        else if (r < SAT_MIN) fin = 14'h2000;
        else                  fin = r[13:0];
        if (RELU_EN != 0 && r[ACC_W-1]) fin = '0;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && last)            state_d = OUT;
            OUT:     if (out_valid_q && out_ready)  state_d = ACCUM;
            default:                                state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

    always_comb begin
        count_d     = count_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            acc_d   = sum;
            count_d = last ? '0 : count_q + CNT_W'(1);
            if (last) begin
                out_data_d  = fin;
                out_valid_d = 1'b1;
            end
        end
        if (state_q == OUT && out_valid_q && out_ready) out_valid_d = 1'b0;
    end
endmodule

// File: tb/tb_conv1_mac_acc.sv
// Directed bench for conv1_mac_acc; runs a ReLU and a non-ReLU instance on shared stimulus.
module tb_conv1_mac_acc;
    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic signed [22:0] in_prod;
    logic signed [22:0] in_bias;
    logic               in_valid;
    logic               out_ready;
    logic               rdy_r, rdy_n;
    logic        [13:0] dat_r, dat_n;
    logic               vld_r, vld_n;

    int n_vec = 0;
    int n_err = 0;

    always #5 ap_clk = ~ap_clk;

    conv1_mac_acc #(.KERNEL_LEN(25), .SHIFT(8), .RELU_EN(1), .ACC_W(29)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_prod(in_prod), .in_bias(in_bias),
        .in_valid(in_valid), .in_ready(rdy_r), .out_data(dat_r), .out_valid(vld_r),
        .out_ready(out_ready));

    conv1_mac_acc #(.KERNEL_LEN(25), .SHIFT(8), .RELU_EN(0), .ACC_W(29)) dut_nr (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_prod(in_prod), .in_bias(in_bias),
        .in_valid(in_valid), .in_ready(rdy_n), .out_data(dat_n), .out_valid(vld_n),
        .out_ready(out_ready));

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic push(input logic signed [22:0] p, input logic signed [22:0] b);
        in_valid = 1'b1;
        in_prod  = p;
        in_bias  = b;
        tick();
        in_valid = 1'b0;
    endtask

    // Feeds a full 25-product window; bias b goes with product 1, b_oth with the rest.
    task automatic window(input string tag, input int p, input int b, input int b_oth,
                          input int exp_r, input int exp_n, input bit ack);
        for (int i = 0; i < 25; i++) begin
            if (i == 24) chk({tag, " vld_before_last"}, vld_r, 0);
            push(23'(p), (i == 0) ? 23'(b) : 23'(b_oth));
        end
        chk({tag, " vld"},     vld_r, 1);
        chk({tag, " vld_nr"},  vld_n, 1);
        chk({tag, " rdy"},     rdy_r, 0);
        chk({tag, " data"},    int'($signed(dat_r)), exp_r);
        chk({tag, " data_nr"}, int'($signed(dat_n)), exp_n);
        if (ack) begin
            tick();
            chk({tag, " vld_clr"}, vld_r, 0);
            chk({tag, " rdy_back"}, rdy_r, 1);
        end
    endtask

    initial begin
        ap_rst_n  = 1'b0;
        in_prod   = '0;
        in_bias   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst vld",  vld_r, 0);
        chk("rst data", dat_r, 0);
        chk("rst rdy",  rdy_r, 1);
        ap_rst_n = 1'b1;

        window("pos100", 100, 0, 0, 10, 10, 1);
        window("neg100", -100, 0, 0, 0, -10, 1);
        window("satmax", 4194303, 4194303, 4194303, 8191, 8191, 1);
        window("satmin", -4194304, -4194304, -4194304, 0, -8192, 1);
        window("bias", 0, 512, 1000, 2, 2, 1);

        // Downstream stalls: output must hold and input pulses must be ignored.
        out_ready = 1'b0;
        window("stall", 100, 0, 0, 10, 10, 0);
        for (int i = 0; i < 4; i++) begin
            push(23'(7777), 23'(4444));
            chk("stall hold vld",  vld_r, 1);
            chk("stall hold data", int'($signed(dat_r)), 10);
            chk("stall hold rdy",  rdy_r, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("stall vld_clr", vld_r, 0);
        chk("stall rdy",     rdy_r, 1);
        window("fresh", 0, 512, 9999, 2, 2, 1);

        // Mid-window reset discards the partial sum.
        for (int i = 0; i < 10; i++) push(23'(5000), 23'(0));
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        chk("midrst vld",  vld_r, 0);
        chk("midrst data", dat_r, 0);
        chk("midrst rdy",  rdy_r, 1);
        window("post_rst", 256, 0, 0, 25, 25, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv1_mac_acc.md
Name: conv1_mac_acc

Overview:
- Accumulation stage directly downstream of the conv1 14s×9u product multiplier.
- Consumes one 23-bit signed product per handshake and sums KERNEL_LEN products per output pixel, plus a per-channel bias.
- Rescales the sum with a rounding arithmetic right shift, saturates it to the 14-bit signed activation format, and optionally applies ReLU.
- Presents each result on a valid/ready output to the next layer stage.

Parameters:
- KERNEL_LEN, 25, products per output window (5×5 kernel); legal range 2..64.
- SHIFT, 8, arithmetic right-shift applied after accumulation; legal range 1..15.
- RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass signed result.
- ACC_W, 29, accumulator width; must be ≥ 23 + ceil(log2(KERNEL_LEN+1)).

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- in_prod  in  23  signed product from the multiplier.
- in_bias  in  23  signed bias, already in product scale; sampled with the first product of each window.
- in_valid  in  1  in_prod (and in_bias) valid.
- in_ready  out  1  stage accepts input this cycle.
- out_data  out  14  signed result (non-negative when RELU_EN=1).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Reset (ap_rst_n low at a clock edge):
  - state=ACCUM, count=0, acc=0, out_valid=0, out_data=0.
  - Any partially accumulated window is discarded; reset takes priority over all other events.
- Input handshake: a product is consumed when in_valid && in_ready at a clock edge. in_valid while in_ready=0 has no effect.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On accept with count==0: acc ← sext(in_bias) + sext(in_prod).
  - On accept with 0<count<KERNEL_LEN-1: acc ← acc + sext(in_prod).
  - count increments on each accept.
  - On accept with count==KERNEL_LEN-1:
    - sum = acc + sext(in_prod).
    - out_data ← final(sum); out_valid ← 1; count ← 0; state ← OUT.
- final(x), computed at ACC_W width:
  1. r = (x + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf).
  2. Saturate r to [-8192, 8191].
  3. If RELU_EN: r<0 → 0.
- State OUT:
  - in_ready=0; out_data and out_valid held stable.
  - On out_valid && out_ready: out_valid ← 0, state ← ACCUM. The next product can be accepted in the following cycle.
- Latency: out_valid rises the cycle after the last product of the window is accepted.
- Throughput: one output per KERNEL_LEN+1 cycles at best.
- No overflow inside acc for legal parameters (width rule above); wrap-around never occurs.
- in_bias is ignored except at count==0.

Test Plan:
- Reset, then 25 products of 100, bias 0, out_ready=1 → out_valid exactly 1 cycle after the 25th accept; out_data=10 ((2500+128)>>8). in_ready=0 for that one cycle.
- 25 products of -100, bias 0:
  - RELU_EN=1 → out_data=0.
  - RELU_EN=0 → out_data=-10 (14'h3FF6).
- 25 products of 4194303 (max), bias 4194303 → out_data=8191 (saturated). With RELU_EN=0, 25 products of -4194304 and bias -4194304 → -8192.
- Products all 0, bias 512 → out_data=2. Bias presented with values ≠512 on products 2..25 is ignored.
- Window complete with out_ready held low 4 cycles → out_data/out_valid stable, in_ready=0 and in_valid pulses ignored. Raise out_ready → handshake, in_ready=1 next cycle, next window accumulates from the correct fresh bias.
- Accept 10 products of 5000, then ap_rst_n low 1 cycle mid-window → out_valid=0, out_data=0. Then 25 products of 256, bias 0 → out_data=25 (partial window discarded).
